fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, drives the instruction memory address, and registers the returned instruction into the IF/ID pipeline register. Applies stall and redirect requests (taken branch, j/jal, jr) from the hazard and branch units. Keeps a count of valid instructions delivered to decode.

---
 rtl/fetch_stage.sv | 94 +++++++++
 tb/tb_fetch_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, imem addressing and the IF/ID pipeline register.
// Redirects beat stalls; a redirect always squashes the instruction being fetched.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 branch_taken,
  input  logic [31:0]          branch_target,
  input  logic                 jump,
  input  logic [25:0]          jump_index,
  input  logic                 jr,
  input  logic [31:0]          jr_target,
  output logic [31:0]          imem_addr,
  input  logic [31:0]          imem_instr,
  output logic [31:0]          ifid_instr,
  output logic [31:0]          ifid_pc_plus4,
  output logic                 ifid_valid,
  output logic [CNT_WIDTH-1:0] fetch_count
);

  logic [31:0]          r_pc;
  logic [31:0]          r_instr;
  logic [31:0]          r_pc4;
  logic                 r_valid;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic [31:0]          w_pc_plus4;
  logic                 w_redirect;
  logic [31:0]          w_target;
  logic [31:0]          w_pc_nxt;
  logic [31:0]          w_instr_nxt;
  logic [31:0]          w_pc4_nxt;
  logic                 w_valid_nxt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_redirect = branch_taken | jr | jump;

  // The EX branch is older than anything in ID, so it wins.
  always_comb begin
    w_target = 32'h0;
    if (branch_taken)
      w_target = {branch_target[31:2], 2'b00};
    else if (jr)
      w_target = {jr_target[31:2], 2'b00};
    else if (jump)
      w_target = {r_pc4[31:28], jump_index, 2'b00};
  end

  always_comb begin
    w_pc_nxt    = r_pc;
    w_instr_nxt = r_instr;
    w_pc4_nxt   = r_pc4;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    if (w_redirect) begin
      w_pc_nxt    = w_target;
      w_instr_nxt = 32'h0;
      w_valid_nxt = 1'b0;
    end else if (!stall) begin
      w_pc_nxt    = w_pc_plus4;
      w_instr_nxt = imem_instr;
      w_pc4_nxt   = w_pc_plus4;
      w_valid_nxt = 1'b1;
      w_cnt_nxt   = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= {RESET_PC[31:2], 2'b00};
      r_instr <= 32'h0;
      r_pc4   <= 32'h0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_instr <= w_instr_nxt;
      r_pc4   <= w_pc4_nxt;
      r_valid <= w_valid_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign imem_addr     = r_pc;
  assign ifid_instr    = r_instr;
  assign ifid_pc_plus4 = r_pc4;
  assign ifid_valid    = r_valid;
  assign fetch_count   = r_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational imem model.
// Expected values are hand-computed from the fetch rules.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic [31:0] fetch_count;

  int n_chk;
  int n_bad;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .CNT_WIDTH(32)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_target    (jr_target),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid   (ifid_valid),
    .fetch_count  (fetch_count)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h2400_0000 | {16'h0, a[15:0]};
  endfunction

  assign imem_instr = mem(imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] pc,
                         input logic [31:0] ins, input logic [31:0] p4,
                         input logic v, input logic [31:0] cnt);
    chk({tag, ".pc"},    imem_addr,     pc);
    chk({tag, ".instr"}, ifid_instr,    ins);
    chk({tag, ".pc4"},   ifid_pc_plus4, p4);
    chk({tag, ".valid"}, {31'h0, ifid_valid}, {31'h0, v});
    chk({tag, ".cnt"},   fetch_count,   cnt);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b0;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    jump = 1'b0;
    jump_index = 26'h0;
    jr = 1'b0;
    jr_target = 32'h0;
    #1;
    chk_all("rst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    #2 reset = 1'b1;

    // sequential fetch
    step(); chk_all("seq1", 32'h4, mem(32'h0), 32'h4, 1'b1, 32'd1);
    step(); chk_all("seq2", 32'h8, mem(32'h4), 32'h8, 1'b1, 32'd2);
    step(); chk_all("seq3", 32'hC, mem(32'h8), 32'hC, 1'b1, 32'd3);

    // jump
    jump = 1'b1; jump_index = 26'h4;
    step(); chk_all("jmp", 32'h10, 32'h0, 32'hC, 1'b0, 32'd3);
    jump = 1'b0;
    step(); chk_all("jmp+1", 32'h14, mem(32'h10), 32'h14, 1'b1, 32'd4);
    step(); step(); step();
    chk_all("to20", 32'h20, mem(32'h1C), 32'h20, 1'b1, 32'd7);

    // stall
    stall = 1'b1;
    step(); chk_all("stl1", 32'h20, mem(32'h1C), 32'h20, 1'b1, 32'd7);
    step(); chk_all("stl2", 32'h20, mem(32'h1C), 32'h20, 1'b1, 32'd7);
    stall = 1'b0;
    step(); chk_all("unstl", 32'h24, mem(32'h20), 32'h24, 1'b1, 32'd8);

    // everything at once: branch wins
    stall = 1'b1;
    branch_taken = 1'b1; branch_target = 32'h0C;
    jr = 1'b1; jr_target = 32'h40;
    jump = 1'b1; jump_index = 26'h3F;
    step(); chk_all("prio", 32'h0C, 32'h0, 32'h24, 1'b0, 32'd8);
    stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;

    // jr beats jump, low bits masked
    jump = 1'b1; jump_index = 26'h3F;
    jr_target = 32'h0000_000F;
    step(); chk("jr_mask", imem_addr, 32'h0C);
    jump = 1'b0;
    jr_target = 32'hFFFF_FFFC;
    step(); chk("jr_top", imem_addr, 32'hFFFF_FFFC);
    jr = 1'b0;
    step(); chk_all("wrap", 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1, 32'd9);

    // jump keeps the upper nibble of pc+4
    jr = 1'b1; jr_target = 32'hF000_0000;
    step(); chk("jr_hi", imem_addr, 32'hF000_0000);
    jr = 1'b0;
    step(); chk("hi_pc4", ifid_pc_plus4, 32'hF000_0004);
    jump = 1'b1; jump_index = 26'h5;
    step(); chk_all("jmp_hi", 32'hF000_0014, 32'h0, 32'hF000_0004, 1'b0, 32'd10);
    jump = 1'b0;
    step(); step();
    chk("cnt12", fetch_count, 32'd12);

    branch_taken = 1'b1; branch_target = 32'h33;
    step(); chk_all("br_mask", 32'h30, 32'h0, 32'hF000_001C, 1'b0, 32'd12);
    branch_taken = 1'b0;

    // asynchronous reset mid-cycle
    #2 reset = 1'b0;
    #1;
    chk_all("arst", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    #2 reset = 1'b1;
    step(); chk_all("restart", 32'h4, mem(32'h0), 32'h4, 1'b1, 32'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
